// File: rtl/io_slave_fabric.sv
// I/O slave fabric: decodes CPU I/O and INTA cycles onto NUM_SLAVES address windows,
// inserts per-slave wait states, handshakes on slave_ready with a timeout, and returns read data.
module io_slave_fabric #(
  parameter int unsigned           NUM_SLAVES = 4,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           WAIT_WIDTH = 4,
  parameter int unsigned           TIMEOUT    = 63,
  parameter int unsigned           INTA_SLAVE = 0,
  parameter logic [DATA_WIDTH-1:0] FILL       = 'hFF
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cpu_clock_negedge,
  input  logic [19:0]                      ADDRESS,
  input  logic                             IOR_N,
  input  logic                             IOW_N,
  input  logic                             INTA_N,
  input  logic                             DEN_N,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] slave_base,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] slave_mask,
  input  logic [NUM_SLAVES*WAIT_WIDTH-1:0] slave_waits,
  input  logic [NUM_SLAVES-1:0]            slave_ready,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_rdata,
  output logic [NUM_SLAVES-1:0]            slave_cs_n,
  output logic [DATA_WIDTH-1:0]            DATA_OUT,
  output logic                             RDY,
  output logic                             bus_error
);

  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]            state;
  logic                  strobe, strobe_q, start, illegal;
  logic                  hit;
  logic [SW-1:0]         sel_d, sel;
  logic                  cyc_read;
  logic [WAIT_WIDTH-1:0] wcnt;
  logic [TW-1:0]         tcnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  unused_addr;

  logic [ADDR_WIDTH-1:0] base_a  [NUM_SLAVES];
  logic [ADDR_WIDTH-1:0] mask_a  [NUM_SLAVES];
  logic [WAIT_WIDTH-1:0] waits_a [NUM_SLAVES];
  logic [DATA_WIDTH-1:0] rdata_a [NUM_SLAVES];

  assign unused_addr = ^ADDRESS;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      base_a[i]  = slave_base[i*ADDR_WIDTH +: ADDR_WIDTH];
      mask_a[i]  = slave_mask[i*ADDR_WIDTH +: ADDR_WIDTH];
      waits_a[i] = slave_waits[i*WAIT_WIDTH +: WAIT_WIDTH];
      rdata_a[i] = slave_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign strobe  = ~IOR_N | ~IOW_N | ~INTA_N;
  assign start   = strobe & ~strobe_q;
  assign illegal = ~IOR_N & ~IOW_N;

  // Simultaneous read and write strobes never select a slave; INTA overrides address decode.
  always_comb begin
    hit   = 1'b0;
    sel_d = '0;
    if (!illegal) begin
      if (!INTA_N) begin
        hit   = 1'b1;
        sel_d = SW'(INTA_SLAVE);
      end else begin
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
          if (!hit && ((ADDRESS[ADDR_WIDTH-1:0] & mask_a[i]) == (base_a[i] & mask_a[i]))) begin
            hit   = 1'b1;
            sel_d = SW'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      strobe_q  <= 1'b0;
      sel       <= '0;
      cyc_read  <= 1'b0;
      wcnt      <= '0;
      tcnt      <= '0;
      rdata_q   <= FILL;
      bus_error <= 1'b0;
    end else begin
      strobe_q  <= strobe;
      bus_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (illegal) begin
              bus_error <= 1'b1;
            end else if (hit) begin
              state    <= S_WAIT;
              sel      <= sel_d;
              cyc_read <= ~IOR_N | ~INTA_N;
              wcnt     <= waits_a[sel_d];
              tcnt     <= '0;
            end
          end
        end
        S_WAIT: begin
          // Abort wins over completion; completion is checked every clock, counting only on ticks.
          if (!strobe) begin
            state <= S_IDLE;
          end else if (wcnt == '0 && slave_ready[sel]) begin
            state <= S_HOLD;
            if (cyc_read) rdata_q <= rdata_a[sel];
          end else if (tcnt == TMAX) begin
            state     <= S_HOLD;
            bus_error <= 1'b1;
            rdata_q   <= FILL;
          end else if (cpu_clock_negedge) begin
            if (wcnt != '0) wcnt <= wcnt - 1'b1;
            else            tcnt <= tcnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (!strobe) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    slave_cs_n = '1;
    if (state != S_IDLE) slave_cs_n[sel] = 1'b0;
  end

  assign RDY      = (state != S_WAIT);
  assign DATA_OUT = (state == S_HOLD && !DEN_N && cyc_read) ? rdata_q : FILL;

endmodule
